// File: rtl/board_tracker.sv
// Connect-four board tracker: per-colour occupancy maps, column heights, draw coordinates and win detection.
// Placements and checks complete in one cycle; the result and place_err are visible the cycle after the request. No backpressure.
module board_tracker #(
  parameter int BOARD_X0 = 24,
  parameter int BOARD_Y0 = 12,
  parameter int CELL     = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       resetb,
  input  logic [6:0] r_col,
  input  logic [6:0] b_col,
  input  logic [6:0] c_col,
  input  logic       checkr,
  input  logic       checkb,
  output logic       win,
  output logic       rwin,
  output logic       bwin,
  output logic [5:0] boardcounter,
  output logic [7:0] draw_x,
  output logic [6:0] draw_y,
  output logic [6:0] col_full,
  output logic       place_err
);

  typedef enum logic [1:0] {IDLE, PLACED, OVER} state_t;

  state_t           state_q, state_d;
  logic [41:0]      red_q, red_d, blue_q, blue_d;
  logic [6:0][2:0]  height_q, height_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             win_q, win_d, rwin_q, rwin_d, bwin_q, bwin_d;
  logic             place_err_q, place_err_d;
  logic [2:0]       last_row_q, last_row_d, last_col_q, last_col_d;
  logic [7:0]       draw_x_q, draw_x_d;
  logic [6:0]       draw_y_q, draw_y_d;

  logic [6:0] req_vec;
  logic       req_red, req_any, place_ok, place_bad, chk_en, win_now;
  logic [2:0] pcol, ph, ccol, ch;

  function automatic logic is_onehot(input logic [6:0] v);
    return (v != 7'd0) && ((v & (v - 7'd1)) == 7'd0);
  endfunction

  function automatic logic [2:0] col_of(input logic [6:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 7; i++)
      if (v[i]) c = 3'(i);
    return c;
  endfunction

  function automatic logic cell_at(input logic [41:0] m, input int r, input int c);
    if (r < 0 || r > 5 || c < 0 || c > 6) return 1'b0;
    return m[6'(r * 7 + c)];
  endfunction

  // Any 4-cell window along each of the four lines that contains (r, c).
  function automatic logic line_win(input logic [41:0] m, input int r, input int c);
    logic hit, run;
    int   dr, dc;
    hit = 1'b0;
    for (int d = 0; d < 4; d++) begin
      dr = (d == 0) ? 0 : 1;
      dc = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
      for (int k = -3; k <= 0; k++) begin
        run = 1'b1;
        for (int j = 0; j < 4; j++)
          run = run & cell_at(m, r + (k + j) * dr, c + (k + j) * dc);
        hit = hit | run;
      end
    end
    return hit;
  endfunction

  always_comb begin
    req_red   = |r_col;
    req_vec   = req_red ? r_col : b_col;
    req_any   = |req_vec;
    pcol      = col_of(req_vec);
    ph        = height_q[pcol];
    place_ok  = req_any && is_onehot(req_vec) && (state_q != OVER) && (ph != 3'd6);
    place_bad = req_any && !place_ok;
    chk_en    = checkr | checkb;
    win_now   = chk_en && line_win(checkr ? red_q : blue_q, int'(last_row_q), int'(last_col_q));
    ccol      = col_of(c_col);
    ch        = height_q[ccol];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_now) state_d = OVER;
               else if (place_ok) state_d = PLACED;
      PLACED:  if (win_now) state_d = OVER;
               else if (place_ok) state_d = PLACED;
               else if (chk_en) state_d = IDLE;
      OVER:    state_d = OVER;
      default: state_d = IDLE;
    endcase
    if (!resetb) state_d = IDLE;
  end

  always_comb begin
    red_d       = red_q;
    blue_d      = blue_q;
    height_d    = height_q;
    cnt_d       = cnt_q;
    win_d       = win_q;
    rwin_d      = rwin_q;
    bwin_d      = bwin_q;
    place_err_d = place_bad;
    last_row_d  = last_row_q;
    last_col_d  = last_col_q;
    draw_x_d    = draw_x_q;
    draw_y_d    = draw_y_q;
    if (place_ok) begin
      if (req_red) red_d[6'(int'(ph) * 7 + int'(pcol))] = 1'b1;
      else         blue_d[6'(int'(ph) * 7 + int'(pcol))] = 1'b1;
      height_d[pcol] = ph + 3'd1;
      if (cnt_q != 6'd42) cnt_d = cnt_q + 6'd1;
      last_row_d = ph;
      last_col_d = pcol;
    end
    if (win_now) begin
      win_d = 1'b1;
      if (checkr) rwin_d = 1'b1;
      else        bwin_d = 1'b1;
    end
    // Origin of the topmost piece in the column; an empty column has none.
    if (is_onehot(c_col) && ch != 3'd0) begin
      draw_x_d = 8'(BOARD_X0 + CELL * int'(ccol));
      draw_y_d = 7'(BOARD_Y0 + CELL * (6 - int'(ch)));
    end
    if (!resetb) begin
      red_d       = '0;
      blue_d      = '0;
      height_d    = '0;
      cnt_d       = '0;
      win_d       = 1'b0;
      rwin_d      = 1'b0;
      bwin_d      = 1'b0;
      place_err_d = 1'b0;
      last_row_d  = '0;
      last_col_d  = '0;
      draw_x_d    = '0;
      draw_y_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      red_q       <= '0;
      blue_q      <= '0;
      height_q    <= '0;
      cnt_q       <= '0;
      win_q       <= 1'b0;
      rwin_q      <= 1'b0;
      bwin_q      <= 1'b0;
      place_err_q <= 1'b0;
      last_row_q  <= '0;
      last_col_q  <= '0;
      draw_x_q    <= '0;
      draw_y_q    <= '0;
    end else begin
      state_q     <= state_d;
      red_q       <= red_d;
      blue_q      <= blue_d;
      height_q    <= height_d;
      cnt_q       <= cnt_d;
      win_q       <= win_d;
      rwin_q      <= rwin_d;
      bwin_q      <= bwin_d;
      place_err_q <= place_err_d;
      last_row_q  <= last_row_d;
      last_col_q  <= last_col_d;
      draw_x_q    <= draw_x_d;
      draw_y_q    <= draw_y_d;
    end
  end

  always_comb begin
    col_full = '0;
    for (int i = 0; i < 7; i++) col_full[i] = (height_q[i] == 3'd6);
  end

  assign win          = win_q;
  assign rwin         = rwin_q;
  assign bwin         = bwin_q;
  assign boardcounter = cnt_q;
  assign draw_x       = draw_x_q;
  assign draw_y       = draw_y_q;
  assign place_err    = place_err_q;

endmodule

// File: doc/board_tracker.md
BOARD_TRACKER -- requirements
Module: board_tracker

Interface
REQ-001 Parameters, one per line: BOARD_X0, 24, pixel x of the left edge of column a.
REQ-002 BOARD_Y0, 12, pixel y of the top edge of row 5 (the top row).
REQ-003 CELL, 16, cell edge in pixels; must be a power of two.
REQ-004 Ports, one per line: clk  in  1  system clock; every register is updated on its rising edge.
REQ-005 resetn  in  1  Asynchronous, active-low reset.
REQ-006 resetb  in  1  Synchronous, active-low soft clear (new game).
REQ-007 r_col  in  7  Place red in the column of the one-hot bit; bit0 = column a, bit6 = column g; each bit is a 1-cycle pulse (r_a..r_g).
REQ-008 b_col  in  7  Place blue in the column of the one-hot bit; bit mapping as r_col (b_a..b_g).
REQ-009 c_col  in  7  Latch draw coordinates for the column of the one-hot bit; bit mapping as r_col (c_a..c_g).
REQ-010 checkr, checkb  in  1 each  Request a win evaluation for red or blue; 1-cycle pulse.
REQ-011 win, rwin, bwin  out  1 each  Sticky game-won flag and the winning colour.
REQ-012 boardcounter  out  6  Number of pieces on the board, 0..42.
REQ-013 draw_x  out  8  Pixel x origin of the last placed cell.
REQ-014 draw_y  out  7  Pixel y origin of the last placed cell.
REQ-015 col_full  out  7  Per-column full flag; bit mapping as r_col.
REQ-016 place_err  out  1  One-cycle pulse: a placement request was rejected.

Function
REQ-017 Board storage: two 42-bit occupancy maps, red and blue. Cell index = row*7 + col; row 0 is the bottom row.
REQ-018 Column heights: seven 3-bit counters, 0..6. col_full[i] = (height[i] == 6).
REQ-019 FSM states: IDLE, PLACED, OVER.
REQ-020 IDLE to PLACED: on a valid placement.
REQ-021 PLACED to IDLE: on checkr or checkb with no win.
REQ-022 PLACED to OVER: on checkr or checkb with a win.
REQ-023 OVER: held until resetb or resetn.
REQ-024 A placement is valid only if all of the following hold: state is not OVER, exactly one bit of the request vector is set, and the target column is not full.
REQ-025 On a valid placement, the same cycle does all of the following: set the bit at cell (height, col) in the colour's map, increment height[col], increment boardcounter, and register last_row = old height and last_col = col.
REQ-026 An invalid request (multi-hot vector, full column, or state OVER) changes no state and pulses place_err for exactly one cycle, the cycle after the request.
REQ-027 Simultaneous nonzero r_col and b_col: only red is considered; blue is dropped with no place_err.
REQ-028 boardcounter saturates at 42 and never wraps.
REQ-029 c_col pulse, any state: draw_x <= BOARD_X0 + CELL*col, draw_y <= BOARD_Y0 + CELL*(5 - (height[col] - 1)), where height[col] is the value before the edge.
REQ-030 c_col pulse on an empty column (height 0): draw_x/draw_y hold their values.
REQ-031 Win check on checkr (or checkb) samples the red (or blue) map and tests four lines through (last_row, last_col): horizontal, vertical, diagonal, anti-diagonal.
REQ-032 A line wins if it holds 4 or more contiguous pieces of that colour. Out-of-board positions count as empty.
REQ-033 Win result latency: registered on the checkr/checkb edge, valid the next cycle (the controller samples it in its update state one cycle after the check).
REQ-034 On a win: win <= 1 and rwin <= 1 (checkr) or bwin <= 1 (checkb). All three are sticky.
REQ-035 checkr and checkb asserted together: only checkr is evaluated.
REQ-036 A check while in IDLE or OVER re-evaluates the last placement; it may set win but never clears it.
REQ-037 Full board with no win: win stays 0 and boardcounter = 42; the downstream controller decides the draw.

Reset
REQ-038 resetn low, asynchronous: maps, heights, boardcounter, win, rwin, bwin, place_err, last_row, last_col, draw_x, draw_y all go to 0; state goes to IDLE; col_full = 0.
REQ-039 resetb low at a clock edge: same values as REQ-038, applied synchronously. resetb overrides any placement or check in that cycle.
REQ-040 resetn asserted mid-placement: no partial update survives; after release the next valid request lands in row 0.

Verification
REQ-041 Place red in a, b, c, d (b_col placements interleaved in g) with checkr after each -> win = 1 and rwin = 1 only on the cycle after the 4th check; boardcounter = 7.
REQ-042 Six b_col = 0000100 pulses, then a 7th -> col_full = 0000100; 7th pulses place_err; boardcounter = 6.
REQ-043 Red diagonal a0, b1, c2, d3 built with filler pieces, checkr after d3 -> rwin = 1; anti-diagonal blue g0, f1, e2, d3 with checkb -> bwin = 1.
REQ-044 c_col = 0001000 after the first piece in column d -> draw_x = 72, draw_y = 92; after the second piece in column d -> draw_y = 76.
REQ-045 r_col = 0000011 -> place_err pulse and no change; r_col and b_col both nonzero -> only red placed.
REQ-046 After a win, any placement -> place_err, board unchanged; resetb low one cycle -> all outputs 0; resetn low mid-sequence -> immediate clear, asynchronous to clk.
